// File: rtl/dct_transpose_pkg.sv
// Shared constants and types for the 2-D DCT pipeline (row stage, transpose, column stage).
package DctPkg;

  localparam int BlockSize = 8;
  localparam int IdxWidth  = $clog2(BlockSize);
  localparam int CoefWidth = 16;

  // One row of coefficients at the default pipeline width, as exchanged between the 1-D stages.
  typedef logic [0:BlockSize-1][CoefWidth-1:0] coefRow_t;

  // Occupancy of one transpose bank.
  typedef enum logic [1:0] {
    BankEmpty   = 2'd0,
    BankFilling = 2'd1,
    BankFull    = 2'd2
  } bankState_e;

endpackage

// File: rtl/axis_reg.sv
// Single-entry valid/ready pipeline register; Enable=0 turns it into plain wires.
module AxisReg #(
  parameter int Width  = 8,
  parameter bit Enable = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [Width-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [Width-1:0] m_data_o
);

  if (Enable) begin : gReg
    logic             valid_q;
    logic [Width-1:0] data_q;

    // The slot can take a new beat when it is empty or being emptied this cycle.
    assign s_ready_o = !valid_q || m_ready_i;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;

    // Load on upstream handshake, otherwise hold so a stalled beat stays stable.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (s_ready_o) begin
        valid_q <= s_valid_i;
        if (s_valid_i) begin
          data_q <= s_data_i;
        end
      end
    end
  end else begin : gBypass
    assign m_valid_o = s_valid_i;
    assign s_ready_o = m_ready_i;
    assign m_data_o  = s_data_i;
  end

endmodule

// File: rtl/dct_transpose_bank.sv
// One 8x8 coefficient bank: whole-row write port, whole-column combinational read port.
module DctTransposeBank
  import DctPkg::*;
#(
  parameter int Width = 16
) (
  input  logic                              clk_i,
  input  logic                              wrEn_i,
  input  logic [IdxWidth-1:0]               wrRow_i,
  input  logic [0:BlockSize-1][Width-1:0]   wrData_i,
  input  logic [IdxWidth-1:0]               rdCol_i,
  output logic [0:BlockSize-1][Width-1:0]   rdData_o
);

  logic [0:BlockSize-1][0:BlockSize-1][Width-1:0] mem_q;

  // Storage is not reset; the bank state in the parent says whether contents are meaningful.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrRow_i] <= wrData_i;
    end
  end

  // Gather element rdCol_i of every stored row to form one column.
  always_comb begin
    rdData_o = '0;
    for (int j = 0; j < BlockSize; j++) begin
      rdData_o[j] = mem_q[j][rdCol_i];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose between the row and column DCT stages: rows in, columns out.
module dct_transpose
  import DctPkg::*;
#(
  parameter int Width     = 16,
  parameter int OutputReg = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  output logic                            s_ready_o,
  input  logic                            s_valid_i,
  input  logic                            s_sof_i,
  input  logic                            s_eol_i,
  input  logic [0:BlockSize-1][Width-1:0] s_data_i,
  input  logic                            m_ready_i,
  output logic                            m_valid_o,
  output logic                            m_sof_o,
  output logic                            m_eol_o,
  output logic [0:BlockSize-1][Width-1:0] m_data_o
);

  // Rows follow the module's Width, so the package row type is re-shaped locally.
  typedef logic [0:BlockSize-1][Width-1:0] row_t;

  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(BlockSize - 1);
  localparam int                  PayloadW = Width * BlockSize + 2;

  bankState_e          bankState_q [2];
  bankState_e          bankState_d [2];
  logic                wrBank_q, wrBank_d;
  logic                rdBank_q, rdBank_d;
  logic [IdxWidth-1:0] rowCnt_q, rowCnt_d;
  logic [IdxWidth-1:0] colCnt_q, colCnt_d;
  logic [1:0]          sof_q, sof_d;
  logic [1:0]          eol_q, eol_d;

  logic                accept;
  logic [IdxWidth-1:0] wrRow;
  logic                wrIsLast;
  logic [1:0]          bankWrEn;
  row_t                bankRd [2];

  logic                rdFull;
  logic                fwdValid;
  logic                rdValid;
  logic                rdReady;
  logic                rdAccept;
  logic                rdSof;
  logic                rdEol;
  row_t                rdCol;
  logic [PayloadW-1:0] rdPayload;
  logic [PayloadW-1:0] outPayload;

  // Input side: a start-of-frame row always lands as row 0, dropping any partial block.
  assign s_ready_o = !rst_i && (bankState_q[wrBank_q] != BankFull);
  assign accept    = s_valid_i && s_ready_o;
  assign wrRow     = s_sof_i ? '0 : rowCnt_q;
  assign wrIsLast  = (wrRow == LastIdx);

  for (genvar b = 0; b < 2; b++) begin : gBank
    assign bankWrEn[b] = accept && (wrBank_q == 1'(b));

    DctTransposeBank #(
      .Width(Width)
    ) uBank (
      .clk_i   (clk_i),
      .wrEn_i  (bankWrEn[b]),
      .wrRow_i (wrRow),
      .wrData_i(s_data_i),
      .rdCol_i (colCnt_q),
      .rdData_o(bankRd[b])
    );
  end

  // With the output register, column 0 is launched while row 7 is still on the input bus,
  // so that row's element is forwarded around the bank to get one cycle of latency.
  assign rdFull   = (bankState_q[rdBank_q] == BankFull);
  assign fwdValid = (OutputReg != 0) && accept && wrIsLast && (wrBank_q == rdBank_q);
  assign rdValid  = rdFull || fwdValid;
  assign rdAccept = rdValid && rdReady;
  assign rdSof    = (colCnt_q == '0) && sof_q[rdBank_q];
  assign rdEol    = (colCnt_q == LastIdx) && eol_q[rdBank_q];

  // Select the read bank's column and splice in the forwarded last-row element.
  always_comb begin
    rdCol = bankRd[rdBank_q];
    if (fwdValid) begin
      rdCol[BlockSize-1] = s_data_i[colCnt_q];
    end
  end

  assign rdPayload = {rdSof, rdEol, rdCol};

  AxisReg #(
    .Width (PayloadW),
    .Enable(OutputReg != 0)
  ) uOutReg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_valid_i(rdValid),
    .s_ready_o(rdReady),
    .s_data_i (rdPayload),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o (outPayload)
  );

  assign m_sof_o  = outPayload[PayloadW-1];
  assign m_eol_o  = outPayload[PayloadW-2];
  assign m_data_o = outPayload[Width*BlockSize-1:0];

  // Next-state for bank occupancy and pointers; read update first so a write to the same bank wins.
  always_comb begin
    bankState_d = bankState_q;
    wrBank_d    = wrBank_q;
    rdBank_d    = rdBank_q;
    rowCnt_d    = rowCnt_q;
    colCnt_d    = colCnt_q;
    sof_d       = sof_q;
    eol_d       = eol_q;

    if (rdAccept) begin
      if (colCnt_q == LastIdx) begin
        bankState_d[rdBank_q] = BankEmpty;
        colCnt_d              = '0;
        rdBank_d              = !rdBank_q;
      end else begin
        colCnt_d = colCnt_q + 1'b1;
      end
    end

    if (accept) begin
      if (wrRow == '0) begin
        sof_d[wrBank_q] = s_sof_i;
      end
      if (wrIsLast) begin
        bankState_d[wrBank_q] = BankFull;
        eol_d[wrBank_q]       = s_eol_i;
        rowCnt_d              = '0;
      end else begin
        bankState_d[wrBank_q] = BankFilling;
        rowCnt_d              = wrRow + 1'b1;
      end
    end

    if ((bankState_d[wrBank_q] == BankFull) && (bankState_d[!wrBank_q] == BankEmpty)) begin
      wrBank_d = !wrBank_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bankState_q <= '{BankEmpty, BankEmpty};
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b0;
      rowCnt_q    <= '0;
      colCnt_q    <= '0;
      sof_q       <= '0;
      eol_q       <= '0;
    end else begin
      bankState_q <= bankState_d;
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      rowCnt_q    <= rowCnt_d;
      colCnt_q    <= colCnt_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose: directed scenarios plus random traffic against a block model.
module tb_dct_transpose;

  localparam int W = 16;
  localparam int N = 8;

  typedef logic [0:N-1][W-1:0] row_t;
  typedef struct {
    row_t data;
    logic sof;
    logic eol;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sReady;
  logic sValid = 1'b0;
  logic sSof   = 1'b0;
  logic sEol   = 1'b0;
  row_t sData  = '0;
  logic mReady = 1'b1;
  logic mValid;
  logic mSof;
  logic mEol;
  row_t mData;

  int errorCount    = 0;
  int checkCount    = 0;
  int cycleCount    = 0;
  int acceptCount   = 0;
  int beatCount     = 0;
  int readyLowCount = 0;
  logic stallPrev   = 1'b0;
  logic partSof     = 1'b0;
  bit randActive    = 1'b0;

  beat_t expQ[$];
  row_t  partRows[$];
  int    beatCycles[$];

  dct_transpose #(
    .Width    (W),
    .OutputReg(1)
  ) dut (
    .clk_i    (clock),
    .rst_i    (reset),
    .s_ready_o(sReady),
    .s_valid_i(sValid),
    .s_sof_i  (sSof),
    .s_eol_i  (sEol),
    .s_data_i (sData),
    .m_ready_i(mReady),
    .m_valid_o(mValid),
    .m_sof_o  (mSof),
    .m_eol_o  (mEol),
    .m_data_o (mData)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic row_t randRow();
    row_t r;
    for (int c = 0; c < N; c++) r[c] = W'($urandom);
    return r;
  endfunction

  // Reference model: collect accepted rows into blocks, emit the transposed columns.
  // Also checks every presented output beat against the head of the expected queue.
  always @(negedge clock) begin
    if (reset) begin
      expQ.delete();
      partRows.delete();
      stallPrev = 1'b0;
    end else begin
      if (sValid && !sReady) readyLowCount++;
      if (sValid && sReady) begin
        acceptCount++;
        if (sSof) partRows.delete();
        if (partRows.size() == 0) partSof = sSof;
        partRows.push_back(sData);
        if (partRows.size() == N) begin
          for (int c = 0; c < N; c++) begin
            beat_t b;
            for (int j = 0; j < N; j++) b.data[j] = partRows[j][c];
            b.sof = (c == 0) && partSof;
            b.eol = (c == N - 1) && sEol;
            expQ.push_back(b);
          end
          partRows.delete();
        end
      end
      if (stallPrev) checkOutput("validHeldUnderStall", mValid, 1'b1);
      if (expQ.size() == 0) begin
        checkOutput("noSpuriousValid", mValid, 1'b0);
      end else if (mValid) begin
        checkOutput("columnBeat", {mSof, mEol, mData}, {expQ[0].sof, expQ[0].eol, expQ[0].data});
        if (mReady) begin
          void'(expQ.pop_front());
          beatCount++;
          beatCycles.push_back(cycleCount);
        end
      end
      stallPrev = mValid && !mReady;
    end
  end

  task automatic applyStimulus(input row_t row, input logic sof, input logic eol);
    int waitCycles = 0;
    sValid = 1'b1;
    sData  = row;
    sSof   = sof;
    sEol   = eol;
    @(negedge clock);
    while (!sReady && waitCycles < 300) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!sReady) checkOutput("inputAcceptTimeout", sReady, 1'b1);
    @(posedge clock);
    #1;
    sValid = 1'b0;
    sSof   = 1'b0;
    sEol   = 1'b0;
  endtask

  task automatic doReset();
    reset  = 1'b1;
    sValid = 1'b0;
    sSof   = 1'b0;
    sEol   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("readyLowInReset", sReady, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("readyAfterReset", sReady, 1'b1);
    checkOutput("validAfterReset", mValid, 1'b0);
    checkOutput("sofEolAfterReset", {mSof, mEol}, 2'b00);
    @(posedge clock);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    checkOutput("drainComplete", expQ.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int startCycle;
    int startBeats;
    row_t r;

    doReset();

    // One block with value 16*row+col, sof on row 0 and eol on row 7; first column one cycle after row 7.
    mReady = 1'b1;
    for (int j = 0; j < N - 1; j++) begin
      for (int c = 0; c < N; c++) r[c] = W'(16 * j + c);
      applyStimulus(r, j == 0, 1'b0);
    end
    for (int c = 0; c < N; c++) r[c] = W'(16 * (N - 1) + c);
    sValid = 1'b1;
    sData  = r;
    sEol   = 1'b1;
    @(negedge clock);
    checkOutput("row7Accepted", sReady, 1'b1);
    checkOutput("noValidBeforeRow7", mValid, 1'b0);
    @(posedge clock);
    #1;
    sValid = 1'b0;
    sEol   = 1'b0;
    @(negedge clock);
    checkOutput("latencyOneCycle", mValid, 1'b1);
    checkOutput("firstColumnData", mData[3], 16'd48);
    waitDrain();

    // Four blocks back to back at full rate: no input stalls, 32 contiguous output beats.
    readyLowCount = 0;
    beatCycles.delete();
    startCycle = cycleCount;
    for (int k = 0; k < 4 * N; k++) applyStimulus(randRow(), (k % N) == 0, (k % N) == N - 1);
    checkOutput("fullRateInputCycles", cycleCount - startCycle, 4 * N);
    waitDrain();
    checkOutput("readyNeverLow", readyLowCount, 0);
    checkOutput("fullRateBeatCount", beatCycles.size(), 4 * N);
    if (beatCycles.size() == 4 * N) checkOutput("noOutputBubbles", beatCycles[4 * N - 1] - beatCycles[0], 4 * N - 1);

    // Downstream stalled for 20 cycles: both banks fill after 16 rows, then nothing more is accepted.
    mReady      = 1'b0;
    startCycle  = cycleCount;
    acceptCount = 0;
    for (int k = 0; k < 2 * N; k++) applyStimulus(randRow(), (k % N) == 0, (k % N) == N - 1);
    checkOutput("acceptedBeforeFull", acceptCount, 2 * N);
    r      = randRow();
    sValid = 1'b1;
    sData  = r;
    sSof   = 1'b1;
    @(negedge clock);
    checkOutput("readyLowWhenBanksFull", sReady, 1'b0);
    while (cycleCount - startCycle < 20) @(posedge clock);
    #1;
    checkOutput("noAcceptWhileFull", acceptCount, 2 * N);
    mReady = 1'b1;
    applyStimulus(r, 1'b1, 1'b0);
    for (int k = 1; k < N; k++) applyStimulus(randRow(), 1'b0, k == N - 1);
    waitDrain();

    // Restart on sof after three rows: only the restarted block comes out.
    startBeats = beatCount;
    applyStimulus(randRow(), 1'b1, 1'b0);
    applyStimulus(randRow(), 1'b0, 1'b0);
    applyStimulus(randRow(), 1'b0, 1'b1);
    for (int k = 0; k < N; k++) applyStimulus(randRow(), k == 0, k == N - 1);
    waitDrain();
    checkOutput("restartBeatCount", beatCount - startBeats, N);

    // Reset after five rows, then a fresh block.
    for (int k = 0; k < 5; k++) applyStimulus(randRow(), k == 0, 1'b0);
    doReset();
    startBeats = beatCount;
    for (int k = 0; k < N; k++) applyStimulus(randRow(), k == 0, k == N - 1);
    waitDrain();
    checkOutput("postResetBeatCount", beatCount - startBeats, N);

    // Random valid gaps, random downstream ready and occasional mid-block sof.
    randActive = 1'b1;
    fork
      begin
        for (int k = 0; k < 160; k++) begin
          int gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clock);
            #1;
          end
          applyStimulus(randRow(), ($urandom_range(0, 15) == 0) || (k == 0), 1'($urandom));
        end
        randActive = 1'b0;
      end
      begin
        while (randActive) begin
          @(posedge clock);
          #1;
          mReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    mReady = 1'b1;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
